mskaes_rr_arbiter: RTL and testbench
====================================

// Module: mskaes_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one masked AES core (aes_enc128_32bits_hpc) between NREQ requester streams.
//  Locks a grant per request, forwards that requester's shared plaintext/key, and tags each accepted block.
//  Routes each ciphertext back to its originating requester, in order, through a tag FIFO.
//  Sits between the requester SVRS streams and the core's in/out SVRS; the seed path bypasses it.
// PARAMETERS
//  d            DEFAULTSHARES  number of shares (passed through to bus widths)
//  NREQ         2              number of requesters, >=2
//  MAX_INFLIGHT 2              tag FIFO depth = max accepted-but-unreturned blocks, >=1
// PORTS
//  clk                    in   1            clock
//  rst                    in   1            synchronous, active high
//  req_valid              in   NREQ         per-requester input valid
//  req_ready              out  NREQ         per-requester input ready
//  req_shares_plaintext   in   NREQ*128*d   requester i at [i*128*d +: 128*d]
//  req_shares_key         in   NREQ*128*d   same packing as plaintext
//  core_in_valid          out  1            to core in_valid
//  core_in_ready          in   1            from core in_ready
//  core_shares_plaintext  out  128*d        to core
//  core_shares_key        out  128*d        to core
//  core_out_valid         in   1            from core out_valid
//  core_out_ready         out  1            to core out_ready
//  core_shares_ciphertext in   128*d        from core
//  rsp_valid              out  NREQ         per-requester output valid (one-hot or zero)
//  rsp_ready              in   NREQ         per-requester output ready
//  rsp_shares_ciphertext  out  128*d        broadcast ciphertext bus (qualified by rsp_valid)
//  busy                   out  1            grant locked or FIFO non-empty
//  err_orphan             out  1            sticky: core_out_valid seen with empty FIFO
// BEHAVIOUR
//  Reset: grant unlocked, rr pointer=0, FIFO empty, err_orphan=0; all valid/ready outputs 0.
//  States: IDLE (no grant) / GRANT(g). Transitions registered; arbitration latency 1 cycle.
//  IDLE: if any req_valid and FIFO not full, pick first valid index at/after pointer (wrap) -> GRANT(g).
//  GRANT(g): core_in_valid=req_valid[g]; req_ready[g]=core_in_ready; other req_ready=0.
//  Handshake (core_in_valid&core_in_ready): push g to FIFO, pointer<=(g+1) mod NREQ, -> IDLE.
//  req_valid[g] dropping while granted (SVRS violation) -> stay in GRANT(g); no re-arbitration.
//  Full check uses registered count: pop and grant in same cycle still blocks grant that cycle.
//  Data mux: selection by registered one-hot grant only, AND-OR per share bit; no shares of
//   different requesters combined; core_shares_* = 0 when IDLE (no stale share glitches).
//  Output: head tag h valid -> rsp_valid[h]=core_out_valid, core_out_ready=rsp_ready[h];
//   rsp_shares_ciphertext = core_shares_ciphertext gated by FIFO non-empty, else 0.
//  Pop on core_out_valid&core_out_ready. Push and pop same cycle: count unchanged.
//  FIFO empty & core_out_valid: core_out_ready=0, err_orphan<=1 (cleared only by rst).
//  Combinational paths: req->core valid and core->rsp valid/ready only; no ready->valid loops.
//  rst mid-operation: grant, FIFO, pointer cleared next edge; core must be reset in the same cycle.
// STRUCTURE
//  Header (design.vh style): TAG_W=$clog2(NREQ), CNT_W=$clog2(MAX_INFLIGHT+1), bus slice macros.
//  Sub-module mskaes_tag_fifo: sync FIFO, width TAG_W, depth MAX_INFLIGHT, push/pop/full/empty/head.
//  Top holds grant FSM, rr pointer, one-hot share muxes, response demux, err flag.
// TESTING
//  Only req0 valid, core ready -> grant cycle 1, handshake, tag 0 pushed; ciphertext -> rsp_valid=2'b01.
//  req0,req1 held valid, NREQ=2, pointer=0 -> accept order 0,1,0,1; rsp routed 0,1,0,1.
//  NREQ=3, req0,req2 valid, pointer=1 -> req2 granted first, then req0.
//  MAX_INFLIGHT=1, core output stalled (rsp_ready=0) -> second request gets req_ready=0 until pop.
//  core_out_valid with empty FIFO -> core_out_ready=0, err_orphan=1 until rst.
//  rst asserted during GRANT(1) with FIFO count 1 -> next cycle all outputs 0, pointer 0, busy 0.

Source files
------------

// File: rtl/mskaes_rr_arbiter_pkg.sv
// Shared types and constants for the masked-AES round-robin arbiter.
// Block width is one AES state; share count scales every data bus.
package mskaes_rr_arbiter_pkg;

  localparam int unsigned DEFAULTSHARES = 2;
  localparam int unsigned BLK_W         = 128;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Width of a field able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mskaes_rr_arbiter_tag_fifo.sv
// Synchronous tag FIFO remembering which requester owns each block inside the core.
// Registered count; push is ignored when full, pop is ignored when empty.
module mskaes_tag_fifo
  import mskaes_rr_arbiter_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int unsigned PTR_W = idx_w(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mskaes_rr_arbiter.sv
// Round-robin share of one masked AES core between NREQ requesters; grant registered (1 cycle),
// valid/ready pass straight through once granted; new grants stall while MAX_INFLIGHT blocks are out.
module mskaes_rr_arbiter
  import mskaes_rr_arbiter_pkg::*;
#(
  parameter int unsigned d            = DEFAULTSHARES,
  parameter int unsigned NREQ         = 2,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*BLK_W*d-1:0]    req_shares_plaintext_i,
  input  logic [NREQ*BLK_W*d-1:0]    req_shares_key_i,
  output logic                       core_in_valid_o,
  input  logic                       core_in_ready_i,
  output logic [BLK_W*d-1:0]         core_shares_plaintext_o,
  output logic [BLK_W*d-1:0]         core_shares_key_o,
  input  logic                       core_out_valid_i,
  output logic                       core_out_ready_o,
  input  logic [BLK_W*d-1:0]         core_shares_ciphertext_i,
  output logic [NREQ-1:0]            rsp_valid_o,
  input  logic [NREQ-1:0]            rsp_ready_i,
  output logic [BLK_W*d-1:0]         rsp_shares_ciphertext_o,
  output logic                       busy_o,
  output logic                       err_orphan_o
);

  localparam int unsigned SHW   = BLK_W * d;
  localparam int unsigned TAG_W = idx_w(NREQ);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [TAG_W-1:0] gidx_q, gidx_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;

  logic             fifo_full, fifo_empty;
  logic [TAG_W-1:0] fifo_head;
  logic             in_hs, out_hs;
  logic             pick_vld, hi_vld;
  logic [TAG_W-1:0] pick_idx, lo_idx, hi_idx;

  // Lowest valid index overall (wrap case) and lowest valid index at/after the pointer.
  always_comb begin
    pick_vld = 1'b0;
    hi_vld   = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        pick_vld = 1'b1;
        lo_idx   = TAG_W'(i);
        if (TAG_W'(i) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = TAG_W'(i);
        end
      end
    end
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld && !fifo_full) begin
          state_d = ARB_GRANT;
          gidx_d  = pick_idx;
          for (int i = 0; i < NREQ; i++) gnt_d[i] = (TAG_W'(i) == pick_idx);
        end
      end
      ARB_GRANT: begin
        // A requester dropping valid mid-grant keeps the lock; only a handshake releases it.
        if (in_hs) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == TAG_W'(NREQ - 1)) ? '0 : gidx_q + TAG_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign core_in_valid_o = |(req_valid_i & gnt_q);
  assign req_ready_o     = gnt_q & {NREQ{core_in_ready_i}};
  assign in_hs           = core_in_valid_o & core_in_ready_i;

  // Registered one-hot select keeps shares of different requesters from ever mixing.
  always_comb begin
    core_shares_plaintext_o = '0;
    core_shares_key_o       = '0;
    for (int i = 0; i < NREQ; i++) begin
      core_shares_plaintext_o = core_shares_plaintext_o
                              | (req_shares_plaintext_i[i*SHW +: SHW] & {SHW{gnt_q[i]}});
      core_shares_key_o       = core_shares_key_o
                              | (req_shares_key_i[i*SHW +: SHW] & {SHW{gnt_q[i]}});
    end
  end

  always_comb begin
    rsp_valid_o      = '0;
    core_out_ready_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!fifo_empty && (fifo_head == TAG_W'(i))) begin
        rsp_valid_o[i]   = core_out_valid_i;
        core_out_ready_o = rsp_ready_i[i];
      end
    end
  end

  assign rsp_shares_ciphertext_o = fifo_empty ? '0 : core_shares_ciphertext_i;
  assign out_hs                  = core_out_valid_i & core_out_ready_o;
  assign err_d                   = err_q | (core_out_valid_i & fifo_empty);
  assign err_orphan_o            = err_q;
  assign busy_o                  = (state_q == ARB_GRANT) | ~fifo_empty;

  mskaes_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (MAX_INFLIGHT),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (in_hs),
    .din_i   (gidx_q),
    .pop_i   (out_hs),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_mskaes_rr_arbiter.sv
// Randomized and directed bench for mskaes_rr_arbiter against a queue-based reference model.
module tb_mskaes_rr_arbiter;

  localparam int N    = 3;
  localparam int MAXI = 2;
  localparam int SW   = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    rv, rr;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [N*SW-1:0] req_pt, req_key;
  logic            cir, civ, cov, cor, busy, err;
  logic [SW-1:0]   core_pt, core_key, ct, rsp_ct;

  mskaes_rr_arbiter #(.d(1), .NREQ(N), .MAX_INFLIGHT(MAXI)) u_dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .req_valid_i              (rv),
    .req_ready_o              (req_ready),
    .req_shares_plaintext_i   (req_pt),
    .req_shares_key_i         (req_key),
    .core_in_valid_o          (civ),
    .core_in_ready_i          (cir),
    .core_shares_plaintext_o  (core_pt),
    .core_shares_key_o        (core_key),
    .core_out_valid_i         (cov),
    .core_out_ready_o         (cor),
    .core_shares_ciphertext_i (ct),
    .rsp_valid_o              (rsp_valid),
    .rsp_ready_i              (rr),
    .rsp_shares_ciphertext_o  (rsp_ct),
    .busy_o                   (busy),
    .err_orphan_o             (err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: lock flag + owner, rr pointer, queue of owners of in-flight blocks.
  bit            m_lock;
  int            m_g, m_ptr;
  int            m_q[$];
  bit            m_err;
  logic [SW-1:0] core_q[$];
  int            accept_log[$], rsp_log[$];
  logic [SW-1:0] pt_a[N], key_a[N];
  bit            out_en, force_orphan;

  task automatic chk(input string tag, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int lg[$], input int exp[$]);
    chk({tag, "_len"}, SW'(lg.size()), SW'(exp.size()));
    for (int i = 0; i < lg.size() && i < exp.size(); i++)
      chk(tag, SW'(lg[i]), SW'(exp[i]));
  endtask

  function automatic logic [SW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic model_clear();
    m_lock = 0; m_g = 0; m_ptr = 0; m_err = 0;
    m_q.delete(); core_q.delete();
  endtask

  task automatic cycle();
    logic [N-1:0]  e_rrdy, e_rspv;
    logic [SW-1:0] e_pt, e_key, e_ct;
    bit            e_civ, e_cor, e_busy, hs, pop;
    int            h, n_before;
    for (int i = 0; i < N; i++) begin
      pt_a[i]  = rand128();
      key_a[i] = rand128();
    end
    req_pt  = {pt_a[2], pt_a[1], pt_a[0]};
    req_key = {key_a[2], key_a[1], key_a[0]};
    cov = force_orphan || (core_q.size() > 0 && out_en);
    ct  = (core_q.size() > 0) ? core_q[0] : rand128();
    @(negedge clk);
    e_civ  = m_lock && bit_of(rv, m_g);
    e_rrdy = (m_lock && cir) ? N'(1 << m_g) : '0;
    e_pt   = m_lock ? pt_a[m_g] : '0;
    e_key  = m_lock ? key_a[m_g] : '0;
    e_rspv = '0; e_cor = 0; e_ct = '0;
    if (m_q.size() > 0) begin
      h      = m_q[0];
      e_rspv = cov ? N'(1 << h) : '0;
      e_cor  = bit_of(rr, h);
      e_ct   = ct;
    end
    e_busy = m_lock || (m_q.size() > 0);
    chk("core_in_valid", SW'(civ), SW'(e_civ));
    chk("req_ready", SW'(req_ready), SW'(e_rrdy));
    chk("core_pt", core_pt, e_pt);
    chk("core_key", core_key, e_key);
    chk("rsp_valid", SW'(rsp_valid), SW'(e_rspv));
    chk("core_out_ready", SW'(cor), SW'(e_cor));
    chk("rsp_ct", rsp_ct, e_ct);
    chk("busy", SW'(busy), SW'(e_busy));
    chk("err_orphan", SW'(err), SW'(m_err));
    hs  = e_civ && cir;
    pop = cov && e_cor;
    if (rst) begin
      model_clear();
    end else begin
      n_before = m_q.size();
      if (pop) begin
        rsp_log.push_back(m_q.pop_front());
        void'(core_q.pop_front());
      end
      if (cov && n_before == 0) m_err = 1;
      if (!m_lock) begin
        if (rv != '0 && n_before < MAXI) begin
          for (int k = N - 1; k >= 0; k--)
            if (bit_of(rv, (m_ptr + k) % N)) m_g = (m_ptr + k) % N;
          m_lock = 1;
        end
      end else if (hs) begin
        m_q.push_back(m_g);
        core_q.push_back(pt_a[m_g] ^ key_a[m_g]);
        accept_log.push_back(m_g);
        m_ptr  = (m_g + 1) % N;
        m_lock = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; rv = '0; rr = '0; cir = 0; out_en = 0; force_orphan = 0;
    cycle();
    rst = 0;
    accept_log.delete();
    rsp_log.delete();
  endtask

  task automatic run_acc(input int n, input int budget);
    for (int c = 0; c < budget && accept_log.size() < n; c++) cycle();
  endtask

  task automatic run_rsp(input int n, input int budget);
    for (int c = 0; c < budget && rsp_log.size() < n; c++) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; rv = '0; rr = '0; cir = 0; cov = 0; out_en = 0; force_orphan = 0;
    req_pt = '0; req_key = '0; ct = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_busy", SW'(busy), '0);
    chk("rst_err", SW'(err), '0);
    chk("rst_civ", SW'(civ), '0);
    chk("rst_cor", SW'(cor), '0);

    // Single requester: grant one cycle after valid, then tag 0 routed back.
    rv = 3'b001; cir = 1; rr = 3'b111;
    cycle();
    chk("t1_grant_civ", SW'(civ), SW'(1));
    run_acc(1, 10);
    rv = '0; out_en = 1;
    run_rsp(1, 10);
    chk_log("t1_acc", accept_log, '{0});
    chk_log("t1_rsp", rsp_log, '{0});

    // Two contenders from pointer 0 alternate.
    do_reset();
    rv = 3'b011; cir = 1; rr = 3'b111; out_en = 1;
    run_acc(4, 40);
    rv = '0;
    run_rsp(4, 40);
    chk_log("t2_acc", accept_log, '{0, 1, 0, 1});
    chk_log("t2_rsp", rsp_log, '{0, 1, 0, 1});

    // Pointer at 1 with req0/req2 valid: req2 wins before req0.
    do_reset();
    rv = 3'b001; cir = 1; rr = 3'b111; out_en = 1;
    run_acc(1, 10);
    rv = 3'b101;
    run_acc(3, 20);
    rv = '0;
    run_rsp(3, 20);
    chk_log("t3_acc", accept_log, '{0, 2, 0});

    // Output stalled: no new grant once MAXI blocks are in flight.
    do_reset();
    rv = 3'b001; cir = 1; rr = '0; out_en = 1;
    repeat (12) cycle();
    chk("t4_acc_cnt", SW'(accept_log.size()), SW'(MAXI));
    chk("t4_req_rdy", SW'(req_ready), '0);
    chk("t4_busy", SW'(busy), SW'(1));
    rr = 3'b111;
    run_acc(MAXI + 1, 20);
    chk("t4_acc_after_pop", SW'(accept_log.size()), SW'(MAXI + 1));
    rv = '0;
    run_rsp(MAXI + 1, 20);
    chk_log("t4_rsp", rsp_log, '{0, 0, 0});

    // Ciphertext with nothing in flight flags a sticky orphan error.
    do_reset();
    rr = 3'b111; force_orphan = 1;
    cycle();
    force_orphan = 0;
    chk("t5_err", SW'(err), SW'(1));
    repeat (5) cycle();
    chk("t5_err_sticky", SW'(err), SW'(1));
    do_reset();
    chk("t5_err_clr", SW'(err), '0);

    // Reset while GRANT(1) with one tag in flight.
    do_reset();
    rv = 3'b010; cir = 1; rr = '0;
    run_acc(1, 10);
    cir = 0;
    repeat (2) cycle();
    chk("t6_busy_pre", SW'(busy), SW'(1));
    chk("t6_rrdy_pre", SW'(req_ready), '0);
    rst = 1;
    cycle();
    rst = 0;
    chk("t6_busy", SW'(busy), '0);
    chk("t6_civ", SW'(civ), '0);
    chk("t6_core_pt", core_pt, '0);
    chk("t6_rsp_valid", SW'(rsp_valid), '0);
    accept_log.delete();
    rv = 3'b111; cir = 1;
    run_acc(1, 10);
    chk_log("t6_ptr0", accept_log, '{0});

    // Random traffic, including valid drops, stalls, orphans and resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(299) == 0);
      rv           = N'($urandom);
      rr           = N'($urandom);
      cir          = ($urandom_range(3) != 0);
      out_en       = ($urandom_range(2) != 0);
      force_orphan = ($urandom_range(499) == 0);
      cycle();
    end
    rst = 0; force_orphan = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
